// File: rtl/max_pool_sched.sv
// ---------------------------------------------------------------------------
// max_pool_sched
//
// Event scheduler and sequencer for the per-grid max-pool datapath
// (max_pool_x). Layer-4 events (x, y, feature pack) are buffered in a small
// FIFO and handed to the pool one at a time. The head event is registered
// onto pool_x/pool_y/pool_feat. The pool then gets one setup cycle, followed
// by a one-cycle pool_start. The scheduler then waits for pool_done. The
// pooled result is captured into an output register that is drained through
// a valid/ready handshake.
//
// Optional feature (macro MAXP_SCHED_WDOG_EN):
//   Adds a WAIT-state watchdog and the sticky wdog_err output. On a timeout
//   the event is dropped and pool_clean pulses for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   event_stream_clean  synchronous flush, same effect as rst
//   in_valid/in_ready   event input handshake; in_x, in_y, in_feat payload
//   pool_clean          reset/flush forwarded to the pool (combinational)
//   pool_start          one-cycle start strobe to the pool
//   pool_x/y/feat       registered event presented to the pool
//   pool_done           pool completion pulse
//   pool_grid_idx       grid index reported by the pool
//   pool_x_out/dx_out   pooled x and pooled dx reported by the pool
//   out_valid/out_ready result handshake
//   out_grid_idx/out_x/out_dx  held result
//   busy                FSM active or FIFO non-empty
//   fifo_count          FIFO occupancy
//   wdog_err            sticky watchdog error (MAXP_SCHED_WDOG_EN only)
// ---------------------------------------------------------------------------
module max_pool_sched #(
    parameter int L4_OUT_C    = 32,
    parameter int F_WIDTH     = 8,
    parameter int X_W         = 7,
    parameter int Y_W         = 7,
    parameter int GI_W        = 6,
    parameter int DEPTH       = 4,
    parameter int WDOG_CYCLES = 16,
    localparam int PW         = L4_OUT_C * F_WIDTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            event_stream_clean,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [X_W-1:0]  in_x,
    input  logic [Y_W-1:0]  in_y,
    input  logic [PW-1:0]   in_feat,
    output logic            pool_clean,
    output logic            pool_start,
    output logic [X_W-1:0]  pool_x,
    output logic [Y_W-1:0]  pool_y,
    output logic [PW-1:0]   pool_feat,
    input  logic            pool_done,
    input  logic [GI_W-1:0] pool_grid_idx,
    input  logic [PW-1:0]   pool_x_out,
    input  logic [PW-1:0]   pool_dx_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GI_W-1:0] out_grid_idx,
    output logic [PW-1:0]   out_x,
    output logic [PW-1:0]   out_dx,
    output logic            busy,
`ifdef MAXP_SCHED_WDOG_EN
    output logic            wdog_err,
`endif
    output logic [CW-1:0]   fifo_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic clean;
    logic push;
    logic pop;
    logic done_accept;
    logic load_head;
    logic wdog_timeout;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [X_W-1:0] fifo_x    [DEPTH];
    logic [Y_W-1:0] fifo_y    [DEPTH];
    logic [PW-1:0]  fifo_feat [DEPTH];

    // Reset and flush share the same path.
    assign clean = rst | event_stream_clean;

    // A push at full is refused even when a pop lands in the same cycle.
    assign in_ready = (fifo_count < CW'(DEPTH));
    assign push     = in_valid & in_ready;

    // The head entry stays in the FIFO while it is being pooled. It is only
    // popped once the pool finishes, or once the watchdog gives up on it.
    assign done_accept = (state == S_WAIT) & pool_done;
    assign pop         = done_accept | wdog_timeout;

    assign busy = (state != S_IDLE) | (fifo_count != '0);

`ifdef MAXP_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt;

    // The timeout fires on the WDOG_CYCLES-th consecutive WAIT cycle without
    // pool_done. A done in that same cycle still wins.
    assign wdog_timeout = (state == S_WAIT) & ~pool_done &
                          (wdog_cnt == WW'(WDOG_CYCLES - 1));

    // The pool is also flushed on a timeout, so it does not carry a stuck
    // job into the next event.
    assign pool_clean = clean | wdog_timeout;

    // The watchdog counter only runs in WAIT. The error flag is sticky until
    // the next reset or flush.
    always_ff @(posedge clk) begin
        if (clean) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state == S_WAIT && !pool_done && !wdog_timeout) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_timeout) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog, WAIT is left only on pool_done. The limit can
    // never be negative, so this term is constant zero. It is written this
    // way so that both builds share one parameter list.
    assign wdog_timeout = (WDOG_CYCLES < 0);
    assign pool_clean   = clean;
`endif

    // FIFO storage. The payload is not reset, because the pointers and count
    // alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr]    <= in_x;
            fifo_y[wr_ptr]    <= in_y;
            fifo_feat[wr_ptr] <= in_feat;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (clean) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clean) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe logic. A new event is only launched once the
    // previous result has been drained. This keeps at most one result in
    // flight beyond the FIFO.
    always_comb begin
        state_nxt  = state;
        load_head  = 1'b0;
        pool_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0 && !out_valid) begin
                    state_nxt = S_SETUP;
                    load_head = 1'b1;
                end
            end
            S_SETUP: begin
                state_nxt = S_START;
            end
            S_START: begin
                pool_start = ~clean;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (pool_done || wdog_timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The event presented to the pool is loaded when leaving IDLE. It is then
    // held untouched through SETUP, START and WAIT.
    always_ff @(posedge clk) begin
        if (clean) begin
            pool_x    <= '0;
            pool_y    <= '0;
            pool_feat <= '0;
        end else if (load_head) begin
            pool_x    <= fifo_x[rd_ptr];
            pool_y    <= fifo_y[rd_ptr];
            pool_feat <= fifo_feat[rd_ptr];
        end
    end

    // Result register. It is filled on pool_done and held until the consumer
    // takes it. A pool_done outside WAIT is ignored.
    always_ff @(posedge clk) begin
        if (clean) begin
            out_valid    <= 1'b0;
            out_grid_idx <= '0;
            out_x        <= '0;
            out_dx       <= '0;
        end else if (done_accept) begin
            out_valid    <= 1'b1;
            out_grid_idx <= pool_grid_idx;
            out_x        <= pool_x_out;
            out_dx       <= pool_dx_out;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_sched.sv
// ---------------------------------------------------------------------------
// tb_max_pool_sched
//
// Directed bench for max_pool_sched. A small behavioural stand-in for the
// max_pool_x datapath keeps a per-grid running maximum. It answers each
// start with done four cycles later. Expected results are hand-computed
// constants pushed into a scoreboard queue when each event is issued. A
// separate monitor pops the queue whenever a result is handed off.
// ---------------------------------------------------------------------------
module tb_max_pool_sched;

    localparam int PW   = 256;
    localparam int GI_W = 6;

    logic            clk;
    logic            rst;
    logic            event_stream_clean;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_x;
    logic [6:0]      in_y;
    logic [PW-1:0]   in_feat;
    logic            pool_clean;
    logic            pool_start;
    logic [6:0]      pool_x;
    logic [6:0]      pool_y;
    logic [PW-1:0]   pool_feat;
    logic            pool_done;
    logic [GI_W-1:0] pool_grid_idx;
    logic [PW-1:0]   pool_x_out;
    logic [PW-1:0]   pool_dx_out;
    logic            out_valid;
    logic            out_ready;
    logic [GI_W-1:0] out_grid_idx;
    logic [PW-1:0]   out_x;
    logic [PW-1:0]   out_dx;
    logic            busy;
    logic [2:0]      fifo_count;
`ifdef MAXP_SCHED_WDOG_EN
    logic            wdog_err;
`endif

    max_pool_sched dut (
        .clk                (clk),
        .rst                (rst),
        .event_stream_clean (event_stream_clean),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_x               (in_x),
        .in_y               (in_y),
        .in_feat            (in_feat),
        .pool_clean         (pool_clean),
        .pool_start         (pool_start),
        .pool_x             (pool_x),
        .pool_y             (pool_y),
        .pool_feat          (pool_feat),
        .pool_done          (pool_done),
        .pool_grid_idx      (pool_grid_idx),
        .pool_x_out         (pool_x_out),
        .pool_dx_out        (pool_dx_out),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_grid_idx       (out_grid_idx),
        .out_x              (out_x),
        .out_dx             (out_dx),
        .busy               (busy),
`ifdef MAXP_SCHED_WDOG_EN
        .wdog_err           (wdog_err),
`endif
        .fifo_count         (fifo_count)
    );

    // Clock and free-running cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Pool stand-in: grid = {y[6:4], x[6:4]}, running per-channel maximum,
    // and dx = new max minus old max. stub_hang suppresses done.
    logic [PW-1:0]   grid_mem [64];
    logic [GI_W-1:0] stub_grid;
    logic [PW-1:0]   stub_feat;
    logic [2:0]      stub_cnt;
    logic            stub_hang;

    always @(posedge clk) begin
        if (pool_clean) begin
            for (int i = 0; i < 64; i++) grid_mem[i] <= '0;
            stub_cnt  <= '0;
            stub_grid <= '0;
            stub_feat <= '0;
        end else begin
            if (pool_start) begin
                stub_cnt  <= 3'd4;
                stub_grid <= {pool_y[6:4], pool_x[6:4]};
                stub_feat <= pool_feat;
            end else if (stub_cnt != 3'd0) begin
                stub_cnt <= stub_cnt - 3'd1;
            end
            if (pool_done) grid_mem[stub_grid] <= pool_x_out;
        end
    end

    assign pool_done     = (stub_cnt == 3'd1) && !stub_hang;
    assign pool_grid_idx = stub_grid;

    always_comb begin
        pool_x_out  = '0;
        pool_dx_out = '0;
        for (int c = 0; c < 32; c++) begin
            pool_x_out[c*8 +: 8] = (stub_feat[c*8 +: 8] > grid_mem[stub_grid][c*8 +: 8]) ?
                                   stub_feat[c*8 +: 8] : grid_mem[stub_grid][c*8 +: 8];
            pool_dx_out[c*8 +: 8] = pool_x_out[c*8 +: 8] - grid_mem[stub_grid][c*8 +: 8];
        end
    end

    // Scoreboard queue of expected results.
    typedef struct {
        logic [GI_W-1:0] grid;
        logic [PW-1:0]   x;
        logic [PW-1:0]   dx;
    } exp_t;

    exp_t exp_q [$];

    task automatic checkOutput(input string name, input logic [PW-1:0] act,
                               input logic [PW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushExpect(input logic [GI_W-1:0] g, input logic [PW-1:0] x,
                              input logic [PW-1:0] dx);
        exp_t e;
        e.grid = g;
        e.x    = x;
        e.dx   = dx;
        exp_q.push_back(e);
    endtask

    // Offers one event starting at a negedge. It holds the event until it is
    // accepted, then returns at the negedge after the push edge. push_cyc is
    // the first cycle in which the event sits in the FIFO.
    task automatic applyStimulus(input logic [6:0] x, input logic [6:0] y,
                                 input logic [PW-1:0] feat, output int push_cyc);
        int waited = 0;
        in_x     = x;
        in_y     = y;
        in_feat  = feat;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("push_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || out_valid || fifo_count != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || out_valid) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic waitStart(output int seen_cyc);
        int n = 0;
        while (!pool_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pool_start) checkOutput("start_timeout", 0, 1);
        seen_cyc = cyc;
    endtask

    // Monitor: compares every handed-off result against the queue. It also
    // checks that a held result stays stable while out_ready is low.
    logic            hold_seen = 1'b0;
    logic [GI_W-1:0] held_grid;
    logic [PW-1:0]   held_x;
    logic [PW-1:0]   held_dx;
    int              start_cnt = 0;

    always @(negedge clk) begin
        if (pool_start) start_cnt++;
        if (rst || event_stream_clean || !out_valid) begin
            hold_seen = 1'b0;
        end else begin
            if (hold_seen) begin
                checkOutput("hold_grid", out_grid_idx, held_grid);
                checkOutput("hold_x", out_x, held_x);
                checkOutput("hold_dx", out_dx, held_dx);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_grid_idx", out_grid_idx, e.grid);
                    checkOutput("out_x", out_x, e.x);
                    checkOutput("out_dx", out_dx, e.dx);
                end
                hold_seen = 1'b0;
            end else begin
                hold_seen = 1'b1;
                held_grid = out_grid_idx;
                held_x    = out_x;
                held_dx   = out_dx;
            end
        end
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    localparam logic [PW-1:0] ALT_0820 = {16{8'h20, 8'h08}};

    initial begin
        int t0;
        int ts;
        int s0;

        rst                = 1'b1;
        event_stream_clean = 1'b0;
        in_valid           = 1'b0;
        in_x               = '0;
        in_y               = '0;
        in_feat            = '0;
        out_ready          = 1'b1;
        stub_hang          = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_pool_clean", pool_clean, 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_fifo_count", fifo_count, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pool_clean_low", pool_clean, 0);

        // Single event: start at T+2 and result at T+7.
        $display("[TB] single event latency");
        pushExpect(6'd0, {32{8'h10}}, {32{8'h10}});
        applyStimulus(7'd5, 7'd3, {32{8'h10}}, t0);
        waitStart(ts);
        checkOutput("start_latency", ts, t0 + 2);
        checkOutput("pool_x", pool_x, 5);
        checkOutput("pool_y", pool_y, 3);
        checkOutput("pool_feat", pool_feat, {32{8'h10}});
        @(negedge clk);
        checkOutput("start_one_cycle", pool_start, 0);
        while (!out_valid && cyc < t0 + 20) @(negedge clk);
        checkOutput("out_valid_latency", cyc, t0 + 7);
        checkOutput("fifo_count_drained", fifo_count, 0);
        waitIdle();

        // Second event into the same grid.
        $display("[TB] second event same grid");
        pushExpect(6'd0, {16{8'h20, 8'h10}}, {16{8'h10, 8'h00}});
        applyStimulus(7'd6, 7'd2, ALT_0820, t0);
        waitIdle();

        // Burst of five with the consumer stalled.
        $display("[TB] burst with stalled consumer");
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++)
            pushExpect(6'(k + 1), {32{8'(8'h30 + k)}}, {32{8'(8'h30 + k)}});
        for (int k = 0; k < 4; k++)
            applyStimulus(7'(16 * (k + 1)), 7'd0, {32{8'(8'h30 + k)}}, t0);
        checkOutput("burst_full_count", fifo_count, 4);
        checkOutput("burst_full_in_ready", in_ready, 0);
        applyStimulus(7'd80, 7'd0, {32{8'h34}}, t0);
        s0 = start_cnt;
        repeat (12) @(negedge clk);
        checkOutput("burst_no_start", start_cnt, s0);
        checkOutput("burst_held_valid", out_valid, 1);
        checkOutput("burst_held_count", fifo_count, 4);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        waitIdle();

        // Flush while WAITing; the next event is first in its grid.
        $display("[TB] flush during wait");
        applyStimulus(7'd5, 7'd3, {32{8'h40}}, t0);
        waitStart(ts);
        @(negedge clk);
        event_stream_clean = 1'b1;
        #1;
        checkOutput("clean_pool_clean", pool_clean, 1);
        @(negedge clk);
        event_stream_clean = 1'b0;
        checkOutput("clean_out_valid", out_valid, 0);
        checkOutput("clean_fifo_count", fifo_count, 0);
        checkOutput("clean_busy", busy, 0);
        checkOutput("clean_pool_x", pool_x, 0);
        pushExpect(6'd0, ALT_0820, ALT_0820);
        applyStimulus(7'd5, 7'd3, ALT_0820, t0);
        waitIdle();

        // Push and pop in the same cycle at count 2.
        $display("[TB] simultaneous push/pop");
        pushExpect(6'd8, {32{8'h61}}, {32{8'h61}});
        pushExpect(6'd9, {32{8'h62}}, {32{8'h62}});
        pushExpect(6'd10, {32{8'h63}}, {32{8'h63}});
        applyStimulus(7'd0, 7'd16, {32{8'h61}}, t0);
        applyStimulus(7'd16, 7'd16, {32{8'h62}}, ts);
        while (cyc < t0 + 6) @(negedge clk);
        checkOutput("pushpop_pre_count", fifo_count, 2);
        applyStimulus(7'd32, 7'd16, {32{8'h63}}, ts);
        checkOutput("pushpop_count", fifo_count, 2);
        waitIdle();

        // Push at full while a pop happens: the push is refused.
        $display("[TB] push at full with pop");
        for (int k = 0; k < 4; k++)
            pushExpect(6'(11 + k), {32{8'(8'h71 + k)}}, {32{8'(8'h71 + k)}});
        applyStimulus(7'd48, 7'd16, {32{8'h71}}, t0);
        for (int k = 1; k < 4; k++)
            applyStimulus(7'(48 + 16 * k), 7'd16, {32{8'(8'h71 + k)}}, ts);
        while (cyc < t0 + 6) @(negedge clk);
        in_x     = 7'd112;
        in_y     = 7'd48;
        in_feat  = {32{8'h7f}};
        in_valid = 1'b1;
        checkOutput("full_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_refused_count", fifo_count, 3);
        waitIdle();

`ifdef MAXP_SCHED_WDOG_EN
        // Watchdog: the pool never answers; the event is dropped.
        $display("[TB] watchdog");
        stub_hang = 1'b1;
        applyStimulus(7'd112, 7'd16, {32{8'h50}}, t0);
        while (cyc < t0 + 18) @(negedge clk);
        checkOutput("wdog_err_before", wdog_err, 0);
        checkOutput("wdog_pool_clean", pool_clean, 1);
        @(negedge clk);
        stub_hang = 1'b0;
        checkOutput("wdog_err_set", wdog_err, 1);
        checkOutput("wdog_fifo_count", fifo_count, 0);
        checkOutput("wdog_out_valid", out_valid, 0);
        pushExpect(6'd23, {32{8'h55}}, {32{8'h55}});
        applyStimulus(7'd112, 7'd32, {32{8'h55}}, t0);
        waitIdle();
        checkOutput("wdog_err_sticky", wdog_err, 1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
